// File: rtl/dec_pkg.sv
// Shared definitions for the registered select decoder.
// Holds the output-width helper, default select/one-hot types and the
// inactive-output constant derived from the output polarity.
package dec_pkg;

  localparam int unsigned DefSelW = 2;

  // Output width is one line per select code.
  function automatic int unsigned out_width(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

  localparam int unsigned DefOutW = out_width(DefSelW);

  typedef logic [DefSelW-1:0] sel_t;
  typedef logic [DefOutW-1:0] onehot_t;

  // All-inactive pattern; callers truncate to their own output width (max 64).
  function automatic logic [63:0] inactive_val(input int unsigned out_act_low);
    return (out_act_low != 0) ? {64{1'b1}} : {64{1'b0}};
  endfunction

  localparam onehot_t InactiveDefault = onehot_t'(inactive_val(0));

endpackage

// File: rtl/dec_onehot_core.sv
// Purely combinational select decoder: one-hot decode of w_i, gated by the
// active-low enable e_i, then polarity applied.
// Ports:
//   e_i  enable, active low (1 forces all-inactive regardless of w_i)
//   w_i  select code, SEL_W bits
//   y_o  decoded lines, 2**SEL_W bits, polarity set by OUT_ACT_LOW
module dec_onehot_core
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned OUT_ACT_LOW = 0
) (
  input  logic                        e_i,
  input  logic [SEL_W-1:0]            w_i,
  output logic [out_width(SEL_W)-1:0] y_o
);

  localparam int unsigned OutW = out_width(SEL_W);

  logic [OutW-1:0] dec;

  always_comb begin
    dec = '0;
    // w_i is only looked at when enabled, so an unknown select cannot leak
    // into the output while disabled.
    if (!e_i) begin
      for (int i = 0; i < int'(OutW); i++) begin
        dec[i] = (w_i == SEL_W'(i));
      end
    end
    y_o = (OUT_ACT_LOW != 0) ? ~dec : dec;
  end

endmodule

// File: rtl/decoder24_en_low.sv
// Registered 2**SEL_W-line decoder with active-low enable.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset; forces y to the inactive value
//   e    enable, active low
//   w    select code, SEL_W bits
//   y    registered decoded output, 2**SEL_W bits
// Build option: define DEC_IN_REG_EN to register e and w ahead of the decode
// (2-cycle latency); otherwise only y is registered (1-cycle latency).
module decoder24_en_low
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned OUT_ACT_LOW = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        e,
  input  logic [SEL_W-1:0]            w,
  output logic [out_width(SEL_W)-1:0] y
);

  localparam int unsigned OutW = out_width(SEL_W);
  localparam logic [OutW-1:0] Inactive = OutW'(inactive_val(OUT_ACT_LOW));

  logic             e_s;
  logic [SEL_W-1:0] w_s;
  logic [OutW-1:0]  y_d;
  logic [OutW-1:0]  y_q;

`ifdef DEC_IN_REG_EN
  logic             e_q;
  logic [SEL_W-1:0] w_q;

  // Reset to disabled so the first post-reset output is inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 1'b1;
      w_q <= '0;
    end else begin
      e_q <= e;
      w_q <= w;
    end
  end

  assign e_s = e_q;
  assign w_s = w_q;
`else
  assign e_s = e;
  assign w_s = w;
`endif

  dec_onehot_core #(
    .SEL_W       (SEL_W),
    .OUT_ACT_LOW (OUT_ACT_LOW)
  ) u_core (
    .e_i (e_s),
    .w_i (w_s),
    .y_o (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= Inactive;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_decoder24_en_low.sv
module tb_decoder24_en_low;
  import dec_pkg::*;

  logic    clk;
  logic    rst;
  logic    e;
  sel_t    w;
  onehot_t y;
  onehot_t y_low;

  int n_cmp;
  int n_err;

  decoder24_en_low #(
    .SEL_W       (2),
    .OUT_ACT_LOW (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .e   (e),
    .w   (w),
    .y   (y)
  );

  decoder24_en_low #(
    .SEL_W       (2),
    .OUT_ACT_LOW (1)
  ) dut_low (
    .clk (clk),
    .rst (rst),
    .e   (e),
    .w   (w),
    .y   (y_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input onehot_t act, input onehot_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference history: inputs applied before the previous edge.
  bit      p_rst = 1'b1;
  bit      p_e   = 1'b1;
  sel_t    p_w   = '0;
  onehot_t last_exp;
  bit      have_last = 1'b0;

  // Apply inputs just after an edge, check y is held mid-cycle, then check the
  // value after the next edge against the reference.
  task automatic step(input bit r, input bit en, input sel_t sel, input string tag);
    bit      active;
    sel_t    code;
    onehot_t exp;
    rst = r;
    e   = en;
    w   = sel;
    #3;
    if (have_last) begin
      check_val({tag, "_hold"}, y, last_exp);
      check_val({tag, "_hold_low"}, y_low, ~last_exp);
    end
    @(posedge clk);
    #1;
`ifdef DEC_IN_REG_EN
    active = !r && !p_rst && !p_e;
    code   = p_w;
`else
    active = !r && !en;
    code   = sel;
`endif
    exp = active ? onehot_t'(1 << code) : '0;
    check_val(tag, y, exp);
    check_val({tag, "_low"}, y_low, ~exp);
    last_exp  = exp;
    have_last = 1'b1;
    p_rst = r;
    p_e   = en;
    p_w   = sel;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    e   = 1'b0;
    w   = 2'd3;

    // Reset with an enabled select pending, then release.
    step(1'b1, 1'b0, 2'd3, "reset0");
    step(1'b1, 1'b0, 2'd3, "reset1");
    step(1'b0, 1'b0, 2'd3, "rel0");
    step(1'b0, 1'b0, 2'd3, "rel1");

    // Enabled sweep, 4 cycles per code.
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, sel_t'(c), "en_sweep");

    // Disabled sweep.
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 2; k++) step(1'b0, 1'b1, sel_t'(c), "dis_sweep");

    // Enable toggle with w held.
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 2'd2, "tog_on");
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 2'd2, "tog_off");
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 2'd2, "tog_on2");

    // Reset in the middle of an active select.
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 2'd1, "mid_pre");
    step(1'b1, 1'b0, 2'd1, "mid_rst");
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 2'd1, "mid_post");

    // Unknown select while disabled stays inactive.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'bxx, "x_dis");
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 2'd0, "x_after");

    // Simultaneous e/w changes and random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           sel_t'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
